// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three requester ports, the stall line and the SRAM macro port.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  im_req;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_gnt;
  logic                  im_rvalid;
  logic [DATA_WIDTH-1:0] im_rdata;

  logic                  dm_rd;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  host_req;
  logic                  host_we;
  logic                  host_lock;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic                  cpu_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  im_req, im_addr,
    output im_gnt, im_rvalid, im_rdata,
    input  dm_rd, dm_wr, dm_addr, dm_w_data,
    output dm_gnt, dm_rvalid, dm_rdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output im_req, im_addr,
    input  im_gnt, im_rvalid, im_rdata,
    output dm_rd, dm_wr, dm_addr, dm_w_data,
    input  dm_gnt, dm_rvalid, dm_rdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter for fetch, data and host ports: one grant per cycle,
// 1-cycle read return to the owner, fetch anti-starvation and host burst lock.
//
// state  | meaning
// ARB    | fixed priority host > dm > im, im promoted after STARVE_MAX denials
// LOCKED | host owns the SRAM; im/dm denied until host_lock drops
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic {ARB, LOCKED} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_IM, TAG_DM, TAG_HOST} tag_t;

  state_t          state_q, state_d;
  tag_t            tag_q, tag_d;
  logic [CW-1:0]   starve_q, starve_d;

  logic                  im_gnt, dm_gnt, host_gnt, dm_any, promote, stall;
  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      tag_q    <= TAG_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  // Grants are forced low while reset is held so nothing reaches the SRAM.
  always_comb begin
    im_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    host_gnt  = 1'b0;
    state_d   = state_q;
    dm_any    = bus.dm_rd | bus.dm_wr;
    promote   = (state_q == ARB) && bus.im_req && (starve_q == STARVE_TOP);
    if (rst) begin
      if (state_q == LOCKED) begin
        host_gnt = bus.host_req;
        if (!bus.host_lock) state_d = ARB;
      end else begin
        if (promote)           im_gnt   = 1'b1;
        else if (bus.host_req) host_gnt = 1'b1;
        else if (dm_any)       dm_gnt   = 1'b1;
        else if (bus.im_req)   im_gnt   = 1'b1;
        if (host_gnt && bus.host_lock) state_d = LOCKED;
      end
    end
  end

  always_comb begin
    mem_en    = im_gnt | dm_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    if (host_gnt) begin
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
      if (!bus.host_we) tag_d = TAG_HOST;
    end else if (dm_gnt) begin
      // A simultaneous rd+wr is a write and produces no read response.
      mem_we    = bus.dm_wr;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_w_data;
      if (!bus.dm_wr) tag_d = TAG_DM;
    end else if (im_gnt) begin
      mem_addr  = bus.im_addr;
      tag_d     = TAG_IM;
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.im_req && !im_gnt)
      starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + CW'(1);
  end

  assign stall = rst && ((bus.im_req && !im_gnt) || (dm_any && !dm_gnt));

  assign bus.im_gnt      = im_gnt;
  assign bus.dm_gnt      = dm_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_stall   = stall;
  assign bus.mem_en      = mem_en;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

  assign bus.im_rvalid   = (tag_q == TAG_IM);
  assign bus.dm_rvalid   = (tag_q == TAG_DM);
  assign bus.host_rvalid = (tag_q == TAG_HOST);
  assign bus.im_rdata    = (tag_q == TAG_IM)   ? bus.mem_rdata : '0;
  assign bus.dm_rdata    = (tag_q == TAG_DM)   ? bus.mem_rdata : '0;
  assign bus.host_rdata  = (tag_q == TAG_HOST) ? bus.mem_rdata : '0;
endmodule
